// File: rtl/slice_checker.sv
// -----------------------------------------------------------------------------
// slice_checker
// Compares the output of a device under check against its stimulus, where
// the expected value is the stimulus (optionally bit-reversed) delayed by
// the device latency LAT. A run covers N_SAMPLES compares. The block keeps
// mismatch statistics and a snapshot of the first failing sample.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   start          one-cycle request to begin a run (ignored while running)
//   in_valid       stim is valid this cycle
//   stim           stimulus driven into the device under check
//   dut_out        device-under-check output
//   busy           a run is in progress
//   done           run complete, held until next start or rst
//   pass           done with zero mismatches
//   mismatch       one-cycle pulse after each failed compare
//   err_count      saturating mismatch count
//   sample_count   number of compares performed
//   first_err_idx  sample_count value at the first mismatch
//   first_err_exp  expected value at the first mismatch
//   first_err_got  dut_out value at the first mismatch
//
// state | meaning
// ------+---------------------------------------------------
// IDLE  | waiting for start after reset
// RUN   | pushing stimulus, comparing delayed expectations
// DONE  | run complete, results held until start
// -----------------------------------------------------------------------------
module slice_checker #(
    parameter int W         = 8,
    parameter int N_SAMPLES = 20000,
    parameter int LAT       = 1,
    parameter int REVERSE   = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         in_valid,
    input  logic [W-1:0] stim,
    input  logic [W-1:0] dut_out,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic         mismatch,
    output logic [15:0]  err_count,
    output logic [15:0]  sample_count,
    output logic [15:0]  first_err_idx,
    output logic [W-1:0] first_err_exp,
    output logic [W-1:0] first_err_got
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Keep the delay-line arrays non-empty even when LAT is 0.
    localparam int PL = (LAT > 0) ? LAT : 1;

    logic [1:0]   r_state;
    logic [PL-1:0] r_pv;
    logic [W-1:0] r_pd [PL];
    logic         r_mismatch;
    logic [15:0]  r_err_count;
    logic [15:0]  r_sample_count;
    logic [15:0]  r_first_idx;
    logic [W-1:0] r_first_exp;
    logic [W-1:0] r_first_got;

    logic [W-1:0] w_map;
    logic         w_cmp_v;
    logic [W-1:0] w_cmp_d;
    logic         w_last;

    always_comb begin
        w_map = '0;
        for (int k = 0; k < W; k++) begin
            w_map[k] = (REVERSE != 0) ? stim[W-1-k] : stim[k];
        end
    end

    // With zero latency the compare sees this cycle's stimulus directly.
    generate
        if (LAT == 0) begin : g_lat0
            assign w_cmp_v = in_valid;
            assign w_cmp_d = w_map;
        end else begin : g_latn
            assign w_cmp_v = r_pv[LAT-1];
            assign w_cmp_d = r_pd[LAT-1];
        end
    endgenerate

    assign w_last = (r_sample_count + 16'd1) == 16'(N_SAMPLES);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_pv           <= '0;
            for (int i = 0; i < PL; i++) r_pd[i] <= '0;
            r_mismatch     <= 1'b0;
            r_err_count    <= '0;
            r_sample_count <= '0;
            r_first_idx    <= '0;
            r_first_exp    <= '0;
            r_first_got    <= '0;
        end else begin
            r_mismatch <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state        <= S_RUN;
                        r_pv           <= '0;
                        r_err_count    <= '0;
                        r_sample_count <= '0;
                        r_first_idx    <= '0;
                        r_first_exp    <= '0;
                        r_first_got    <= '0;
                    end
                end
                S_RUN: begin
                    r_pv[0] <= in_valid;
                    r_pd[0] <= w_map;
                    for (int i = 1; i < PL; i++) begin
                        r_pv[i] <= r_pv[i-1];
                        r_pd[i] <= r_pd[i-1];
                    end
                    if (w_cmp_v) begin
                        r_sample_count <= r_sample_count + 16'd1;
                        if (w_cmp_d != dut_out) begin
                            r_mismatch <= 1'b1;
                            if (r_err_count != 16'hFFFF)
                                r_err_count <= r_err_count + 16'd1;
                            // err_count saturates and never wraps, so zero
                            // reliably marks the first failure of the run.
                            if (r_err_count == 16'd0) begin
                                r_first_idx <= r_sample_count;
                                r_first_exp <= w_cmp_d;
                                r_first_got <= dut_out;
                            end
                        end
                        if (w_last) r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy          = (r_state == S_RUN);
    assign done          = (r_state == S_DONE);
    // err_count is updated on the same edge that enters DONE, so a failing
    // final compare is already reflected here.
    assign pass          = (r_state == S_DONE) && (r_err_count == 16'd0);
    assign mismatch      = r_mismatch;
    assign err_count     = r_err_count;
    assign sample_count  = r_sample_count;
    assign first_err_idx = r_first_idx;
    assign first_err_exp = r_first_exp;
    assign first_err_got = r_first_got;

endmodule

// File: tb/tb_slice_checker.sv
module tb_slice_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] stim = '0;
    logic [7:0] dut_out = '0;
    logic       start_a = 0, start_b = 0, start_c = 0, start_d = 0, start_r = 0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // u_a: identity, LAT=1, N=4
    logic a_busy, a_done, a_pass, a_mm;
    logic [15:0] a_ec, a_sc, a_fi;
    logic [7:0]  a_fe, a_fg;
    slice_checker #(.W(8), .N_SAMPLES(4), .LAT(1), .REVERSE(0)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .in_valid(in_valid), .stim(stim),
        .dut_out(dut_out), .busy(a_busy), .done(a_done), .pass(a_pass), .mismatch(a_mm),
        .err_count(a_ec), .sample_count(a_sc), .first_err_idx(a_fi),
        .first_err_exp(a_fe), .first_err_got(a_fg));

    // u_b: reverse, LAT=0, N=2
    logic b_busy, b_done, b_pass, b_mm;
    logic [15:0] b_ec, b_sc, b_fi;
    logic [7:0]  b_fe, b_fg;
    slice_checker #(.W(8), .N_SAMPLES(2), .LAT(0), .REVERSE(1)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .in_valid(in_valid), .stim(stim),
        .dut_out(dut_out), .busy(b_busy), .done(b_done), .pass(b_pass), .mismatch(b_mm),
        .err_count(b_ec), .sample_count(b_sc), .first_err_idx(b_fi),
        .first_err_exp(b_fe), .first_err_got(b_fg));

    // u_c: identity, LAT=2, N=3
    logic c_busy, c_done, c_pass, c_mm;
    logic [15:0] c_ec, c_sc, c_fi;
    logic [7:0]  c_fe, c_fg;
    slice_checker #(.W(8), .N_SAMPLES(3), .LAT(2), .REVERSE(0)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .in_valid(in_valid), .stim(stim),
        .dut_out(dut_out), .busy(c_busy), .done(c_done), .pass(c_pass), .mismatch(c_mm),
        .err_count(c_ec), .sample_count(c_sc), .first_err_idx(c_fi),
        .first_err_exp(c_fe), .first_err_got(c_fg));

    // u_d: identity, LAT=0, N=65535
    logic d_busy, d_done, d_pass, d_mm;
    logic [15:0] d_ec, d_sc, d_fi;
    logic [7:0]  d_fe, d_fg;
    slice_checker #(.W(8), .N_SAMPLES(65535), .LAT(0), .REVERSE(0)) u_d (
        .clk(clk), .rst(rst), .start(start_d), .in_valid(in_valid), .stim(stim),
        .dut_out(dut_out), .busy(d_busy), .done(d_done), .pass(d_pass), .mismatch(d_mm),
        .err_count(d_ec), .sample_count(d_sc), .first_err_idx(d_fi),
        .first_err_exp(d_fe), .first_err_got(d_fg));

    // u_r: reverse, LAT=3, N=16 (randomized against the model)
    localparam int R_LAT = 3;
    localparam int R_N   = 16;
    logic r_busy, r_done, r_pass, r_mm;
    logic [15:0] r_ec, r_sc, r_fi;
    logic [7:0]  r_fe, r_fg;
    slice_checker #(.W(8), .N_SAMPLES(R_N), .LAT(R_LAT), .REVERSE(1)) u_r (
        .clk(clk), .rst(rst), .start(start_r), .in_valid(in_valid), .stim(stim),
        .dut_out(dut_out), .busy(r_busy), .done(r_done), .pass(r_pass), .mismatch(r_mm),
        .err_count(r_ec), .sample_count(r_sc), .first_err_idx(r_fi),
        .first_err_exp(r_fe), .first_err_got(r_fg));

    function automatic logic [7:0] rev8(input logic [7:0] x);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = x[7-i];
        return r;
    endfunction

    task automatic drive(input logic v, input logic [7:0] s, input logic [7:0] d);
        in_valid = v;
        stim     = s;
        dut_out  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic run_a_matching();
        drive(1'b1, 8'hA5, 8'h00);
        drive(1'b1, 8'h3C, 8'hA5);
        drive(1'b1, 8'h00, 8'h3C);
        drive(1'b1, 8'hFF, 8'h00);
        drive(1'b0, 8'h00, 8'hFF);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 8'h00, 8'h00);
        drive(1'b0, 8'h00, 8'h00);
        rst = 1'b0;
        n_vec++;
        if ({a_busy, a_done, a_pass, a_mm} !== 4'b0000) begin
            n_err++; $display("FAIL reset_flags got=%b exp=0000", {a_busy, a_done, a_pass, a_mm});
        end
        n_vec++;
        if ({a_ec, a_sc, a_fi, a_fe, a_fg} !== 64'h0) begin
            n_err++; $display("FAIL reset_counters got=%h exp=0", {a_ec, a_sc, a_fi, a_fe, a_fg});
        end
        drive(1'b1, 8'h12, 8'h34);
        n_vec++;
        if (a_busy !== 1'b0 || a_sc !== 16'd0) begin
            n_err++; $display("FAIL idle_ignores_valid busy=%b sc=%0d exp busy=0 sc=0", a_busy, a_sc);
        end
    endtask

    task automatic test_identity();
        start_a = 1'b1;
        drive(1'b0, 8'h00, 8'h00);
        start_a = 1'b0;
        n_vec++;
        if (a_busy !== 1'b1 || a_sc !== 16'd0) begin
            n_err++; $display("FAIL ident_start busy=%b sc=%0d exp busy=1 sc=0", a_busy, a_sc);
        end
        run_a_matching();
        n_vec++;
        if ({a_done, a_pass, a_busy} !== 3'b110 || a_ec !== 16'd0 || a_sc !== 16'd4) begin
            n_err++; $display("FAIL ident_done done/pass/busy=%b ec=%0d sc=%0d exp 110 ec=0 sc=4",
                              {a_done, a_pass, a_busy}, a_ec, a_sc);
        end
    endtask

    task automatic test_reverse();
        start_b = 1'b1;
        drive(1'b0, 8'h00, 8'h00);
        start_b = 1'b0;
        drive(1'b1, 8'h01, 8'h80);
        n_vec++;
        if (b_sc !== 16'd1 || b_mm !== 1'b0 || b_busy !== 1'b1) begin
            n_err++; $display("FAIL rev_first sc=%0d mm=%b busy=%b exp sc=1 mm=0 busy=1", b_sc, b_mm, b_busy);
        end
        drive(1'b1, 8'h02, 8'h02);
        n_vec++;
        if (b_mm !== 1'b1 || b_done !== 1'b1 || b_pass !== 1'b0 || b_ec !== 16'd1) begin
            n_err++; $display("FAIL rev_final mm=%b done=%b pass=%b ec=%0d exp mm=1 done=1 pass=0 ec=1",
                              b_mm, b_done, b_pass, b_ec);
        end
        n_vec++;
        if (b_fi !== 16'd1 || b_fe !== 8'h40 || b_fg !== 8'h02) begin
            n_err++; $display("FAIL rev_first_err idx=%0d exp_v=%h got_v=%h exp idx=1 40 02", b_fi, b_fe, b_fg);
        end
        drive(1'b1, 8'h55, 8'h00);
        n_vec++;
        if (b_mm !== 1'b0 || b_done !== 1'b1 || b_sc !== 16'd2 || b_ec !== 16'd1) begin
            n_err++; $display("FAIL rev_hold mm=%b done=%b sc=%0d ec=%0d exp 0 1 2 1", b_mm, b_done, b_sc, b_ec);
        end
    endtask

    task automatic test_gaps();
        logic [7:0] s [3];
        int exp_cnt;
        s[0] = 8'h11; s[1] = 8'h22; s[2] = 8'h33;
        exp_cnt = 0;
        start_c = 1'b1;
        drive(1'b0, 8'h00, 8'h00);
        start_c = 1'b0;
        for (int t = 0; t < 9; t++) begin
            logic       v;
            logic       cmp;
            logic [7:0] sv, dv;
            v   = (t % 3 == 0);
            sv  = v ? s[t/3] : 8'hC3;
            cmp = (t >= 2) && ((t - 2) % 3 == 0);
            // gap cycles carry a value that would mismatch if compared
            dv  = cmp ? s[(t-2)/3] : 8'hEE;
            drive(v, sv, dv);
            if (cmp) exp_cnt++;
            n_vec++;
            if (c_sc !== 16'(exp_cnt) || c_mm !== 1'b0) begin
                n_err++; $display("FAIL gap_cycle t=%0d sc=%0d mm=%b exp sc=%0d mm=0", t, c_sc, c_mm, exp_cnt);
            end
        end
        n_vec++;
        if (c_done !== 1'b1 || c_pass !== 1'b1 || c_ec !== 16'd0) begin
            n_err++; $display("FAIL gap_done done=%b pass=%b ec=%0d exp 1 1 0", c_done, c_pass, c_ec);
        end
    endtask

    task automatic test_restart();
        start_a = 1'b1;
        drive(1'b0, 8'h00, 8'h00);
        start_a = 1'b0;
        drive(1'b1, 8'hA5, 8'h00);
        drive(1'b1, 8'h3C, 8'hA5);
        start_a = 1'b1;
        drive(1'b1, 8'h00, 8'h3C);
        start_a = 1'b0;
        n_vec++;
        if (a_sc !== 16'd2 || a_busy !== 1'b1) begin
            n_err++; $display("FAIL start_in_run sc=%0d busy=%b exp sc=2 busy=1", a_sc, a_busy);
        end
        drive(1'b1, 8'hFF, 8'h00);
        drive(1'b0, 8'h00, 8'h12);
        n_vec++;
        if (a_done !== 1'b1 || a_pass !== 1'b0 || a_ec !== 16'd1 || a_fi !== 16'd3 ||
            a_fe !== 8'hFF || a_fg !== 8'h12) begin
            n_err++; $display("FAIL restart_run_end done=%b pass=%b ec=%0d idx=%0d e=%h g=%h exp 1 0 1 3 ff 12",
                              a_done, a_pass, a_ec, a_fi, a_fe, a_fg);
        end
        start_a = 1'b1;
        drive(1'b0, 8'h00, 8'h00);
        start_a = 1'b0;
        n_vec++;
        if (a_busy !== 1'b1 || a_done !== 1'b0 || {a_ec, a_sc, a_fi, a_fe, a_fg} !== 64'h0) begin
            n_err++; $display("FAIL start_in_done busy=%b done=%b counters=%h exp busy=1 done=0 counters=0",
                              a_busy, a_done, {a_ec, a_sc, a_fi, a_fe, a_fg});
        end
    endtask

    task automatic test_abort();
        // u_a is running with an empty pipeline after test_restart
        drive(1'b1, 8'hA5, 8'h00);
        drive(1'b1, 8'h3C, 8'hA5);
        drive(1'b0, 8'h00, 8'h3C);
        n_vec++;
        if (a_sc !== 16'd2) begin
            n_err++; $display("FAIL abort_pre sc=%0d exp 2", a_sc);
        end
        rst = 1'b1;
        start_a = 1'b1;
        drive(1'b0, 8'h00, 8'h00);
        rst = 1'b0;
        start_a = 1'b0;
        n_vec++;
        if (a_busy !== 1'b0 || a_done !== 1'b0 || a_sc !== 16'd0 || a_pass !== 1'b0) begin
            n_err++; $display("FAIL abort busy=%b done=%b sc=%0d pass=%b exp 0 0 0 0", a_busy, a_done, a_sc, a_pass);
        end
        start_a = 1'b1;
        drive(1'b0, 8'h00, 8'h00);
        start_a = 1'b0;
        run_a_matching();
        n_vec++;
        if (a_done !== 1'b1 || a_pass !== 1'b1 || a_sc !== 16'd4) begin
            n_err++; $display("FAIL abort_fresh done=%b pass=%b sc=%0d exp 1 1 4", a_done, a_pass, a_sc);
        end
    endtask

    task automatic test_random();
        logic       hv [400];
        logic [7:0] hd [400];
        int  cnt, errs, fidx;
        logic [7:0] fexp, fgot;
        bit  finished;
        cnt = 0; errs = 0; fidx = 0; fexp = '0; fgot = '0; finished = 0;
        start_r = 1'b1;
        drive(1'b0, 8'h00, 8'h00);
        start_r = 1'b0;
        for (int t = 0; t < 400 && !finished; t++) begin
            logic       v, cmp, mm;
            logic [7:0] s, d, e;
            v = ($urandom_range(0, 2) != 0);
            s = 8'($urandom);
            hv[t] = v;
            hd[t] = rev8(s);
            cmp = (t >= R_LAT) && hv[t-R_LAT];
            e   = cmp ? hd[t-R_LAT] : 8'h00;
            d   = (cmp && $urandom_range(0, 3) != 0) ? e : 8'($urandom);
            drive(v, s, d);
            mm = cmp && (d != e);
            if (cmp) begin
                if (mm) begin
                    if (errs == 0) begin fidx = cnt; fexp = e; fgot = d; end
                    errs++;
                end
                cnt++;
            end
            n_vec++;
            if (r_mm !== mm || r_sc !== 16'(cnt) || r_ec !== 16'(errs)) begin
                n_err++; $display("FAIL rand_cycle t=%0d mm=%b sc=%0d ec=%0d exp mm=%b sc=%0d ec=%0d",
                                  t, r_mm, r_sc, r_ec, mm, cnt, errs);
            end
            if (cnt == R_N) finished = 1;
        end
        n_vec++;
        if (!finished) begin
            n_err++; $display("FAIL rand_timeout sc=%0d exp %0d", r_sc, R_N);
        end
        n_vec++;
        if (r_done !== 1'b1 || r_pass !== (errs == 0) || r_fi !== 16'(fidx) ||
            r_fe !== fexp || r_fg !== fgot) begin
            n_err++; $display("FAIL rand_end done=%b pass=%b idx=%0d e=%h g=%h exp 1 %b %0d %h %h",
                              r_done, r_pass, r_fi, r_fe, r_fg, (errs == 0), fidx, fexp, fgot);
        end
    endtask

    task automatic test_saturate();
        start_d = 1'b1;
        drive(1'b0, 8'h00, 8'h00);
        start_d = 1'b0;
        for (int i = 0; i < 65535; i++) drive(1'b1, 8'h00, 8'hFF);
        n_vec++;
        if (d_done !== 1'b1 || d_pass !== 1'b0 || d_ec !== 16'hFFFF || d_sc !== 16'hFFFF) begin
            n_err++; $display("FAIL sat_end done=%b pass=%b ec=%h sc=%h exp 1 0 ffff ffff", d_done, d_pass, d_ec, d_sc);
        end
        n_vec++;
        if (d_fi !== 16'd0 || d_fe !== 8'h00 || d_fg !== 8'hFF) begin
            n_err++; $display("FAIL sat_first idx=%0d e=%h g=%h exp 0 00 ff", d_fi, d_fe, d_fg);
        end
        drive(1'b1, 8'h00, 8'hFF);
        n_vec++;
        if (d_ec !== 16'hFFFF || d_sc !== 16'hFFFF || d_mm !== 1'b0) begin
            n_err++; $display("FAIL sat_hold ec=%h sc=%h mm=%b exp ffff ffff 0", d_ec, d_sc, d_mm);
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_reverse();
        test_gaps();
        test_restart();
        test_abort();
        test_random();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/slice_checker.md
SLICE_CHECKER -- requirements
Module: slice_checker

Interface
REQ-001 The module SHALL have parameter W, default 8, meaning the data width in bits.
REQ-002 The module SHALL have parameter N_SAMPLES, default 20000, meaning the number of compared samples per run (1..65535).
REQ-003 The module SHALL have parameter LAT, default 1, meaning the device-under-check latency in clocks (0..4).
REQ-004 The module SHALL have parameter REVERSE, default 0, meaning the expected-output mapping: 0 = identity, 1 = bit reversal (exp[k] = stim[W-1-k]).
REQ-005 The module SHALL have these ports:
- clk  input  1  the single clock; all logic is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a run.
- in_valid  input  1  stim is valid this cycle.
- stim  input  W  stimulus vector driven into the device under check.
- dut_out  input  W  device-under-check output.
- busy  output  1  a run is in progress.
- done  output  1  the run is complete; held until the next start or rst.
- pass  output  1  done with zero mismatches.
- mismatch  output  1  one-cycle pulse on each failed compare.
- err_count  output  16  number of mismatches, saturating.
- sample_count  output  16  number of compares performed.
- first_err_idx  output  16  sample_count value at the first mismatch.
- first_err_exp  output  W  expected value at the first mismatch.
- first_err_got  output  W  dut_out value at the first mismatch.

Function
REQ-006 The block SHALL implement the FSM states IDLE, RUN and DONE.
REQ-007 IDLE->RUN SHALL occur on start=1, and in the same edge err_count, sample_count, first_err_* and the latency pipeline SHALL be cleared.
REQ-008 In RUN, each in_valid=1 cycle SHALL push {stim mapped per REVERSE} into a LAT-deep valid/data delay line. When LAT=0, the compare SHALL use the current cycle's values.
REQ-009 A compare SHALL occur in each RUN cycle where the delayed valid is 1: exp is checked against dut_out of that cycle, and sample_count increments by 1.
REQ-010 On exp != dut_out, the block SHALL:
- assert mismatch for exactly the next cycle;
- increment err_count, saturating at 16'hFFFF;
- on the first mismatch only, latch first_err_idx (the pre-increment sample_count), first_err_exp and first_err_got.
REQ-011 When sample_count becomes N_SAMPLES, the FSM SHALL go RUN->DONE on that edge, and further in_valid SHALL be ignored.
REQ-012 In DONE, the block SHALL hold done=1 and pass = (err_count==0), and SHALL hold all counters.
REQ-013 start SHALL be ignored while in RUN.
REQ-014 start in DONE SHALL behave as in IDLE (clear, then RUN).
REQ-015 busy SHALL equal (state==RUN), and done SHALL equal (state==DONE).
REQ-016 in_valid gaps SHALL NOT advance sample_count; entries already in the delay line are still compared.
REQ-017 On a simultaneous final compare and mismatch, the mismatch SHALL be counted before pass is evaluated.

Reset
REQ-018 While rst=1 at a clock edge, the block SHALL set:
- state = IDLE;
- busy, done, pass and mismatch to 0;
- err_count, sample_count and first_err_idx to 0;
- first_err_exp and first_err_got to 0;
- all delay-line valids to 0.
REQ-019 rst SHALL take priority over start.
REQ-020 rst during RUN SHALL abort the run, with no done pulse.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Identity, LAT=1, N_SAMPLES=4; start, then stim 8'hA5,8'h3C,8'h00,8'hFF with dut_out matching one cycle later -> done=1, pass=1, err_count=0, sample_count=4.
- REVERSE=1, LAT=0, N_SAMPLES=2; stim 8'h01 with dut_out 8'h80, then stim 8'h02 with dut_out 8'h02 -> err_count=1, first_err_idx=1, first_err_exp=8'h40, first_err_got=8'h02, pass=0.
- LAT=2, N_SAMPLES=3, with in_valid gaps of 2 cycles between samples and a matching DUT -> sample_count=3 and pass=1, and no compare occurs in the gap cycles.
- start pulsed again in RUN mid-run -> no clear and no restart; start in DONE -> counters cleared and busy=1 on the next cycle.
- rst asserted after 2 of 4 samples -> busy=0, done=0, sample_count=0; a fresh start then completes normally.
- Forced all-mismatch with N_SAMPLES=65535 -> err_count=16'hFFFF (saturated), first_err_idx=0, pass=0.
